// File: rtl/key_debounce.sv
// key_debounce: conditions a raw push-button pin into clean, clock-synchronous
// events. It synchronises the pin, debounces it with a stability counter, and
// classifies each debounced press as a click or a long press.
//
// Event timing, with the edge that first samples a raw change counted as edge 1:
//   - A change that stays stable reaches key_level on edge DEBOUNCE_CYCLES+2.
//     Two edges go to the synchroniser. The counter then needs DEBOUNCE_CYCLES
//     further edges of disagreement before it toggles.
//   - long_pulse fires exactly LONG_CYCLES cycles after the press_pulse cycle.
//   - If the release and the long threshold land in the same cycle, the release
//     wins and the press is reported as a click.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned LONG_CYCLES     = 27000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_raw,
  output logic       key_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       click_pulse,
  output logic       long_pulse,
  output logic       hold,
  output logic [7:0] press_count
);

  // One extra bit keeps the terminal value representable for every legal
  // parameter value, including DEBOUNCE_CYCLES = 1.
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES) + 1;

  // The pin level while the button is untouched.
  localparam logic IDLE_LEVEL = logic'(ACTIVE_LOW);

  // Terminal counts. Each counter stops here and never runs past it.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_LONG    = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic s1_q;
  logic s2_q;

  // Two-flop synchroniser. Reset loads the idle level so that a key held
  // through reset looks like a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= IDLE_LEVEL;
      s2_q <= IDLE_LEVEL;
    end else begin
      s1_q <= key_raw;
      s2_q <= s1_q;
    end
  end

  // Normalised pressed level: 1 means the button is down, whatever the polarity.
  logic p_now;
  assign p_now = s2_q ^ IDLE_LEVEL;

  // ---------------------------------------------------------------------------
  // Debounce counter
  // ---------------------------------------------------------------------------
  logic            level_q;
  logic            level_d;
  logic [DB_W-1:0] db_cnt_q;
  logic [DB_W-1:0] db_cnt_d;
  logic            mismatch;
  logic            db_done;
  logic            press_evt;
  logic            release_evt;

  // Count cycles in which the synchronised input disagrees with the accepted
  // level. When the counter reaches its terminal count and the input still
  // disagrees, accept the new level.
  always_comb begin
    mismatch    = (p_now != level_q);
    db_done     = mismatch && (db_cnt_q == DB_LAST);
    press_evt   = db_done && !level_q;
    release_evt = db_done && level_q;
    level_d     = db_done ? ~level_q : level_q;
    if (!mismatch || db_done) begin
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Debounced level, its counter, and the edge strobes derived from it.
  logic       press_q;
  logic       release_q;
  logic [7:0] count_q;
  logic [7:0] count_d;

  // The press counter is 8 bits wide, so it wraps from 255 back to 0 on its own.
  assign count_d = press_evt ? (count_q + 8'd1) : count_q;

  // Registered debounce state. The strobes change on the same edge as the level.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q   <= 1'b0;
      db_cnt_q  <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      level_q   <= level_d;
      db_cnt_q  <= db_cnt_d;
      press_q   <= press_evt;
      release_q <= release_evt;
      count_q   <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Press classifier
  // ---------------------------------------------------------------------------
  state_t              state_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic                click_q;
  logic                long_q;
  logic                hold_q;

  // Click / long-press state machine with registered strobes.
  //
  // The machine reacts to the debounce events directly rather than to
  // key_level. This keeps every strobe aligned with the level change.
  //
  // The hold counter is 0 on entry to PRESSED and equals k after the k-th cycle
  // in that state. The long strobe therefore lands exactly LONG_CYCLES cycles
  // after press_pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= '0;
      click_q    <= 1'b0;
      long_q     <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      click_q <= 1'b0;
      long_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          hold_cnt_q <= '0;
          if (press_evt) begin
            state_q <= S_PRESSED;
          end
        end
        S_PRESSED: begin
          // The release is checked first so that it beats a coincident threshold.
          if (release_evt) begin
            state_q    <= S_IDLE;
            click_q    <= 1'b1;
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_q <= S_LONG;
            long_q  <= 1'b1;
            hold_q  <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        S_LONG: begin
          // The hold counter stays parked at its terminal value until release.
          if (release_evt) begin
            state_q    <= S_IDLE;
            hold_q     <= 1'b0;
            hold_cnt_q <= '0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          hold_cnt_q <= '0;
          hold_q     <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign key_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign click_pulse   = click_q;
  assign long_pulse    = long_q;
  assign hold          = hold_q;
  assign press_count   = count_q;

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Input-side counterpart to the LED output path: conditions a raw board push-button (Tang Nano 9K user key) into clean, clock-synchronous events.
- Synchronises the raw pin, debounces it, and classifies each press as a click or a long press.
- Sits between the key pin and control logic such as rate select or counter enable.

Parameters:
DEBOUNCE_CYCLES, 270000, consecutive stable cycles required to accept a level change (10 ms at 27 MHz); must be >= 1
LONG_CYCLES, 27000000, cycles a debounced press must last to count as a long press (1 s at 27 MHz); must be >= 2
ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
key_raw  input  1  asynchronous raw button pin
key_level  output  1  debounced level, 1 = pressed
press_pulse  output  1  one-cycle strobe on debounced press
release_pulse  output  1  one-cycle strobe on debounced release
click_pulse  output  1  one-cycle strobe on release of a press that never became long
long_pulse  output  1  one-cycle strobe when a press reaches LONG_CYCLES
hold  output  1  high from long_pulse until release
press_count  output  8  count of debounced presses, wraps

Behaviour:
- Synchroniser: 2 flops (s1, s2). On reset both load the idle pin level (ACTIVE_LOW ? 1 : 0). Normalised input p = s2 XOR ACTIVE_LOW.
- Debounce counter:
  - Cleared whenever p == key_level.
  - Otherwise increments each cycle.
  - In the cycle it equals DEBOUNCE_CYCLES-1 with p != key_level still true, key_level toggles on that edge and the counter clears.
  - Latency: a raw change held stable moves key_level exactly DEBOUNCE_CYCLES+2 edges after the first edge that samples it.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles after synchronisation produces no output change.
- press_pulse / release_pulse:
  - High during the first cycle that key_level is 1 (press) or 0 (release), respectively.
  - Registered, coincident with the key_level change.
  - Never both high in the same cycle.
- press_count: increments on the cycle press_pulse is high; 255 wraps to 0.
- State machine, states IDLE, PRESSED, LONG:
  - IDLE: on debounced press go to PRESSED; hold counter cleared.
  - PRESSED: hold counter increments each cycle.
    - If it equals LONG_CYCLES-1 while the key is still pressed, go to LONG.
    - long_pulse is high for 1 cycle, exactly LONG_CYCLES cycles after the press_pulse cycle.
    - hold rises in the same cycle as long_pulse.
  - PRESSED + debounced release: go to IDLE; release_pulse and click_pulse high in the same cycle.
  - LONG + debounced release: go to IDLE; release_pulse high, click_pulse stays 0, hold falls in the release cycle.
  - Release and long threshold in the same cycle: release wins. Result is click_pulse, not long_pulse.
- Reset:
  - All outputs 0, press_count 0, key_level 0, counters 0, state IDLE.
  - Reset mid-press or mid-hold discards the press.
  - If the key is still held after reset, it is re-qualified: press_pulse fires DEBOUNCE_CYCLES+2 edges after rst deasserts.
- Counter widths: $clog2 of the respective parameter, plus 1. No overflow: each counter stops at its threshold.

Test Plan:
- Bench parameters unless stated: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1.
- Reset: rst=1 for 3 cycles with key_raw=0 -> all outputs 0 throughout. After release, key still held -> press_pulse exactly 6 edges after rst falls, press_count=1.
- Bounce: key_raw sequence 0,0,0,1,1,0,0,1 then steady 1 -> key_level stays 0, no pulses. Then key_raw=0 steady -> key_level=1 and press_pulse for 1 cycle, 6 edges after the first 0 sample.
- Click: debounced press held 10 cycles then key_raw=1 -> release_pulse and click_pulse together for 1 cycle, long_pulse and hold never 1, key_level low 6 edges after raw release.
- Long press: held 40 cycles -> long_pulse 1 cycle, exactly 20 cycles after press_pulse; hold=1 until the release cycle; release_pulse=1 and click_pulse=0.
- Wrap: 257 clean presses -> press_count reads 255 after the 255th press, 0 after the 256th, 1 after the 257th.
- Reset in LONG: assert rst while hold=1 -> next cycle hold=0, state IDLE, no release_pulse. With key still held after deassert -> new press_pulse at +6 edges, long_pulse 20 cycles later.
